// File: rtl/jk_excitation_driver.sv
// ============================================================================
// Module   : jk_excitation_driver
// Purpose  : Turns LOAD/INC/DEC/INVERT commands into per-bit J/K drive for an
//            external JK bank. It also keeps a shadow model of that bank.
//            Optional macro: JK_FB_CHECK_EN (feedback compare on err).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_excitation_driver #(
  parameter int WIDTH = 8,
  parameter int XFILL = 0
) (
  input  logic             clock_pos,
  input  logic             reset_neg,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] signal_J,
  output logic [WIDTH-1:0] signal_K,
  output logic             signal_fire,
  input  logic [WIDTH-1:0] signal_fb,
  output logic [WIDTH-1:0] model_q,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] c_op_load = 2'b00;
  localparam logic [1:0] c_op_inc  = 2'b01;
  localparam logic [1:0] c_op_dec  = 2'b10;
  localparam logic [1:0] c_op_inv  = 2'b11;
  localparam logic [WIDTH-1:0] c_xf = (XFILL != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRIVE = 2'd1, S_SETTLE = 2'd2} state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_op, w_op_nxt;
  logic [WIDTH-1:0] r_data, w_data_nxt;
  logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] w_model_nxt, w_j_nxt, w_k_nxt;
  logic             w_fire_nxt, w_done_nxt;
  logic [WIDTH-1:0] w_q_post, w_n;
  logic [1:0]       w_exc_op;
  logic [WIDTH-1:0] w_exc_q, w_exc_data, w_exc_j, w_exc_k, w_mask;

  // Value of the bank after the step currently being driven.
  always_comb begin
    w_q_post = model_q;
    case (r_op)
      c_op_load: w_q_post = r_data;
      c_op_inc:  w_q_post = model_q + WIDTH'(1);
      c_op_dec:  w_q_post = model_q - WIDTH'(1);
      default:   w_q_post = ~model_q;
    endcase
  end

  // In IDLE the first step is built from the incoming command; in DRIVE the
  // next step is built from the value the current step will leave behind.
  assign w_exc_op   = (r_state == S_IDLE) ? cmd_op   : r_op;
  assign w_exc_data = (r_state == S_IDLE) ? cmd_data : r_data;
  assign w_exc_q    = (r_state == S_IDLE) ? model_q  : w_q_post;

  always_comb begin
    w_mask  = '0;
    w_exc_j = '0;
    w_exc_k = '0;
    case (w_exc_op)
      c_op_load: begin
        w_exc_j = (~w_exc_q & w_exc_data) | (w_exc_q & c_xf);
        w_exc_k = (w_exc_q & ~w_exc_data) | (~w_exc_q & c_xf);
      end
      c_op_inc: begin
        w_mask  = w_exc_q ^ (w_exc_q + WIDTH'(1));
        w_exc_j = w_mask;
        w_exc_k = w_mask;
      end
      c_op_dec: begin
        w_mask  = w_exc_q ^ (w_exc_q - WIDTH'(1));
        w_exc_j = w_mask;
        w_exc_k = w_mask;
      end
      default: begin
        w_exc_j = '1;
        w_exc_k = '1;
      end
    endcase
  end

  assign w_n = (cmd_op == c_op_load || cmd_op == c_op_inv) ? WIDTH'(1) : cmd_data;

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_data_nxt  = r_data;
    w_cnt_nxt   = r_cnt;
    w_model_nxt = model_q;
    w_j_nxt     = '0;
    w_k_nxt     = '0;
    w_fire_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_op_nxt   = cmd_op;
          w_data_nxt = cmd_data;
          w_cnt_nxt  = w_n;
          if (w_n == '0) begin
            w_state_nxt = S_SETTLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_DRIVE;
            w_fire_nxt  = 1'b1;
            w_j_nxt     = w_exc_j;
            w_k_nxt     = w_exc_k;
          end
        end
      end
      S_DRIVE: begin
        w_model_nxt = w_q_post;
        if (r_cnt == WIDTH'(1)) begin
          w_state_nxt = S_SETTLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt  = r_cnt - WIDTH'(1);
          w_fire_nxt = 1'b1;
          w_j_nxt    = w_exc_j;
          w_k_nxt    = w_exc_k;
        end
      end
      S_SETTLE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_pos or negedge reset_neg) begin
    if (!reset_neg) begin
      r_state     <= S_IDLE;
      r_op        <= c_op_load;
      r_data      <= '0;
      r_cnt       <= '0;
      model_q     <= '0;
      signal_J    <= '0;
      signal_K    <= '0;
      signal_fire <= 1'b0;
      done        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      r_data      <= w_data_nxt;
      r_cnt       <= w_cnt_nxt;
      model_q     <= w_model_nxt;
      signal_J    <= w_j_nxt;
      signal_K    <= w_k_nxt;
      signal_fire <= w_fire_nxt;
      done        <= w_done_nxt;
    end
  end

  assign cmd_ready = (r_state == S_IDLE) && reset_neg;

`ifdef JK_FB_CHECK_EN
  // The bank has settled by the SETTLE cycle, so the compare is qualified by done.
  assign err = done && (signal_fb != model_q);
`else
  logic w_unused_fb;
  assign w_unused_fb = ^signal_fb;
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_jk_excitation_driver.sv
// ============================================================================
// Module   : tb_jk_excitation_driver
// Purpose  : Directed self-checking bench for jk_excitation_driver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jk_excitation_driver;

  logic       clock_pos = 1'b0;
  logic       reset_neg = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op    = 2'b00;
  logic [7:0] cmd_data  = 8'h00;
  logic [7:0] signal_J, signal_K, signal_fb, model_q;
  logic       signal_fire, done, err;

  int n_tests = 0;
  int n_fail  = 0;

  jk_excitation_driver #(.WIDTH(8), .XFILL(0)) dut (
    .clock_pos  (clock_pos),
    .reset_neg  (reset_neg),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .signal_J   (signal_J),
    .signal_K   (signal_K),
    .signal_fire(signal_fire),
    .signal_fb  (signal_fb),
    .model_q    (model_q),
    .done       (done),
    .err        (err)
  );

  always #5 clock_pos = ~clock_pos;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge inside c1.
  task automatic issue(input logic [1:0] op, input logic [7:0] data);
    cmd_op    = op;
    cmd_data  = data;
    cmd_valid = 1'b1;
    @(negedge clock_pos);
    cmd_valid = 1'b0;
  endtask

  initial begin
    signal_fb = 8'h00;
    #1;
    chk("rst_J", signal_J, 8'h00);
    chk("rst_K", signal_K, 8'h00);
    chk("rst_fire", signal_fire, 1'b0);
    chk("rst_model", model_q, 8'h00);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    @(negedge clock_pos);
    @(negedge clock_pos);
    reset_neg = 1'b1;
    #1;
    chk("ready_after_rst", cmd_ready, 1'b1);
    @(negedge clock_pos);

    // LOAD 0xA5 from 0x00
    issue(2'b00, 8'hA5);
    chk("t1_c1_fire", signal_fire, 1'b1);
    chk("t1_c1_J", signal_J, 8'hA5);
    chk("t1_c1_K", signal_K, 8'h00);
    chk("t1_c1_ready", cmd_ready, 1'b0);
    chk("t1_c1_done", done, 1'b0);
    @(negedge clock_pos);
    chk("t1_c2_done", done, 1'b1);
    chk("t1_c2_model", model_q, 8'hA5);
    chk("t1_c2_fire", signal_fire, 1'b0);
    chk("t1_c2_J", signal_J, 8'h00);
    chk("t1_c2_err", err, 1'b0);
    @(negedge clock_pos);
    chk("t1_c3_ready", cmd_ready, 1'b1);
    chk("t1_c3_done", done, 1'b0);

    // LOAD 0x3C from 0xA5
    issue(2'b00, 8'h3C);
    chk("t2_c1_J", signal_J, 8'h18);
    chk("t2_c1_K", signal_K, 8'h81);
    @(negedge clock_pos);
    chk("t2_c2_done", done, 1'b1);
    chk("t2_c2_model", model_q, 8'h3C);
    @(negedge clock_pos);

    // LOAD 0xFE, then INC 3 with a stray request while busy
    issue(2'b00, 8'hFE);
    @(negedge clock_pos);
    chk("t3_pre_model", model_q, 8'hFE);
    @(negedge clock_pos);
    issue(2'b01, 8'd3);
    chk("t3_c1_J", signal_J, 8'h01);
    chk("t3_c1_K", signal_K, 8'h01);
    chk("t3_c1_model", model_q, 8'hFE);
    cmd_op = 2'b00; cmd_data = 8'h77; cmd_valid = 1'b1;
    @(negedge clock_pos);
    chk("t3_c2_J", signal_J, 8'hFF);
    chk("t3_c2_K", signal_K, 8'hFF);
    chk("t3_c2_model", model_q, 8'hFF);
    @(negedge clock_pos);
    chk("t3_c3_J", signal_J, 8'h01);
    chk("t3_c3_model", model_q, 8'h00);
    chk("t3_c3_fire", signal_fire, 1'b1);
    @(negedge clock_pos);
    cmd_valid = 1'b0;
    chk("t3_c4_done", done, 1'b1);
    chk("t3_c4_model", model_q, 8'h01);
    chk("t3_c4_fire", signal_fire, 1'b0);
    @(negedge clock_pos);
    chk("t3_c5_idle_model", model_q, 8'h01);
    chk("t3_c5_ready", cmd_ready, 1'b1);

    // LOAD 0x00, DEC 1 (wrap), INC 0
    issue(2'b00, 8'h00);
    chk("t4_load0_J", signal_J, 8'h00);
    chk("t4_load0_K", signal_K, 8'h01);
    @(negedge clock_pos);
    @(negedge clock_pos);
    issue(2'b10, 8'd1);
    chk("t4_dec_J", signal_J, 8'hFF);
    chk("t4_dec_K", signal_K, 8'hFF);
    @(negedge clock_pos);
    chk("t4_dec_done", done, 1'b1);
    chk("t4_dec_model", model_q, 8'hFF);
    @(negedge clock_pos);
    issue(2'b01, 8'd0);
    chk("t4_inc0_done", done, 1'b1);
    chk("t4_inc0_fire", signal_fire, 1'b0);
    chk("t4_inc0_J", signal_J, 8'h00);
    chk("t4_inc0_model", model_q, 8'hFF);
    @(negedge clock_pos);
    chk("t4_inc0_ready", cmd_ready, 1'b1);

    // INC 5 from 0xFF, reset during c2
    issue(2'b01, 8'd5);
    chk("t5_c1_J", signal_J, 8'hFF);
    @(negedge clock_pos);
    chk("t5_c2_J", signal_J, 8'h01);
    chk("t5_c2_model", model_q, 8'h00);
    reset_neg = 1'b0;
    #1;
    chk("t5_rst_fire", signal_fire, 1'b0);
    chk("t5_rst_J", signal_J, 8'h00);
    chk("t5_rst_K", signal_K, 8'h00);
    chk("t5_rst_done", done, 1'b0);
    @(negedge clock_pos);
    reset_neg = 1'b1;
    #1;
    chk("t5_ready", cmd_ready, 1'b1);
    @(negedge clock_pos);
    chk("t5_no_done", done, 1'b0);
    chk("t5_no_fire", signal_fire, 1'b0);
    issue(2'b00, 8'h01);
    chk("t5_load_J", signal_J, 8'h01);
    chk("t5_load_K", signal_K, 8'h00);
    @(negedge clock_pos);
    chk("t5_load_done", done, 1'b1);
    chk("t5_load_model", model_q, 8'h01);
    @(negedge clock_pos);

    // INVERT from 0x01
    issue(2'b11, 8'h5A);
    chk("inv_J", signal_J, 8'hFF);
    chk("inv_K", signal_K, 8'hFF);
    @(negedge clock_pos);
    chk("inv_model", model_q, 8'hFE);
    chk("inv_done", done, 1'b1);
    @(negedge clock_pos);

    // Feedback compare on LOAD 0x0F
    issue(2'b00, 8'h0F);
    @(negedge clock_pos);
    signal_fb = 8'h0E;
    #1;
    chk("t6_done", done, 1'b1);
`ifdef JK_FB_CHECK_EN
    chk("t6_err_bad", err, 1'b1);
    signal_fb = 8'h0F;
    #1;
    chk("t6_err_good", err, 1'b0);
`else
    chk("t6_err_off", err, 1'b0);
`endif
    @(negedge clock_pos);
    chk("t6_err_clear", err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jk_excitation_driver.md
Name: jk_excitation_driver

Overview:
- Command-driven controller that generates per-bit J/K excitation for an external bank of WIDTH JK flip-flops with asynchronous preset/clear, sharing this block's clock and reset.
- Keeps a shadow model of the bank. Turns LOAD/INC/DEC/INVERT commands into one or more cycles of J/K drive, with a fire strobe that the bank uses as its clock enable.
- Sits between a register-file or sequencer front end and discrete JK storage.

Parameters:
- WIDTH, 8, width of the JK bank, command data and feedback.
- XFILL, 0, value driven on the don't-care half of each excitation pair (0 or 1).

Ports:
- clock_pos  input  1  clock; all state changes on the rising edge.
- reset_neg  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high exactly while in IDLE.
- cmd_op  input  2  00 LOAD, 01 INC, 10 DEC, 11 INVERT.
- cmd_data  input  WIDTH  LOAD: target value; INC/DEC: step count n; INVERT: ignored.
- signal_J  output  WIDTH  registered J vector to the bank.
- signal_K  output  WIDTH  registered K vector to the bank.
- signal_fire  output  1  registered; the bank samples J/K on an edge where this is 1.
- signal_fb  input  WIDTH  bank Q outputs, fed back.
- model_q  output  WIDTH  shadow copy of the bank contents.
- done  output  1  one-cycle completion pulse.
- err  output  1  feedback mismatch flag, valid while done=1.

Behaviour:
- Reset (asynchronous, active-low, effective immediately, including mid-command):
  - State goes to IDLE; in-flight command is abandoned with no done pulse.
  - signal_J=0, signal_K=0, signal_fire=0, model_q=0, done=0, err=0.
  - cmd_ready=1 once reset_neg is high.
  - The bank is cleared by the same reset_neg, so model_q=0 stays consistent with it.
- States: IDLE, DRIVE, SETTLE.
- IDLE:
  - J=K=0, fire=0.
  - Accept when cmd_valid & cmd_ready at an edge (edge c0); latch op and data.
  - Step count N: LOAD=1, INVERT=1, INC/DEC=cmd_data.
  - N>=1 → DRIVE. N=0 → SETTLE directly, with no fire cycle.
- DRIVE, cycles c1..cN:
  - fire=1 every cycle; J/K are registered, computed from the model value that precedes the step.
  - model_q takes the post-step value at the end edge of each cycle. Step counter decrements; after step N → SETTLE.
- Per-step excitation rules (q = model before the step):
  - LOAD, per bit:
    - 0→0: J=0, K=XFILL.
    - 0→1: J=1, K=XFILL.
    - 1→0: J=XFILL, K=1.
    - 1→1: J=XFILL, K=0.
  - INC: toggle mask = bits 0..i, where i is the index of the lowest 0 in q. If q is all-ones, all bits toggle and the value wraps to 0. J=K=mask.
  - DEC: toggle mask = bits 0..i, where i is the index of the lowest 1 in q. If q=0, all bits toggle and the value wraps to all-ones. J=K=mask.
  - INVERT: J=K=all-ones.
  - Bits not in the mask (INC/DEC): J=K=0.
  - Arithmetic is modulo 2^WIDTH.
- SETTLE, cycle cN+1:
  - fire=0, J=K=0, done=1 for exactly this cycle.
  - err per Optional Feature.
  - Next state IDLE; cmd_ready=1 from cycle cN+2.
- Commands are not accepted while busy; cmd_valid outside IDLE is ignored. Back-to-back commands cost one IDLE cycle minimum.
- Total latency, accept edge to done: N+1 cycles.

Optional Feature:
- Macro: JK_FB_CHECK_EN.
- Defined:
  - In SETTLE, err = (signal_fb != model_q), registered with done. err returns to 0 in the next cycle.
  - model_q is not overwritten from feedback.
- Undefined:
  - signal_fb is unused and err is tied to 0.
  - State sequence and timing are identical.

Test Plan:
1. Reset release, then LOAD 0xA5 with XFILL=0 → c1: fire=1, J=0xA5, K=0x00; c2: done=1, model_q=0xA5.
2. From 0xA5, LOAD 0x3C → c1: J=0x18, K=0x81; done at c2; model_q=0x3C.
3. From 0xFE, INC n=3 → J=K masks 0x01, 0xFF, 0x01 over c1..c3; model_q sequence 0xFF, 0x00, 0x01; done at c4.
4. From 0x00, DEC n=1 → J=K=0xFF, model_q=0xFF. Then INC n=0 → no fire cycle, done in c1, model_q unchanged.
5. reset_neg low during c2 of INC n=5 → outputs 0 asynchronously; no done; cmd_ready=1 after release; next LOAD 0x01 completes normally.
6. With JK_FB_CHECK_EN: LOAD 0x0F with signal_fb forced to 0x0E in SETTLE → done=1, err=1. With signal_fb=0x0F → err=0.
